// File: rtl/sobel_ctrl_pkg.sv
// Shared types, widths and the saturating threshold step helper used by the
// Sobel threshold controller.
package sobel_ctrl_pkg;

   localparam int unsigned THR_W = 11;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCUM  = 2'd1,
      UPDATE = 2'd2,
      APPLY  = 2'd3
   } state_e;

   // One guard bit above THR_W so an up-step never wraps before the clamp.
   function automatic logic [THR_W-1:0] sat_step(
      input logic [THR_W-1:0] value,
      input logic             up,
      input logic             down,
      input logic [THR_W-1:0] step,
      input logic [THR_W-1:0] min,
      input logic [THR_W-1:0] max
   );
      logic [THR_W:0] wide;
      wide = {1'b0, value};
      if (up && !down) begin
         wide = wide + {1'b0, step};
      end else if (down && !up) begin
         if (wide < {1'b0, step}) begin
            wide = '0;
         end else begin
            wide = wide - {1'b0, step};
         end
      end
      if (wide > {1'b0, max}) begin
         wide = {1'b0, max};
      end
      if (wide < {1'b0, min}) begin
         wide = {1'b0, min};
      end
      return wide[THR_W-1:0];
   endfunction

endpackage

// File: rtl/edge_pixel_counter.sv
// Saturating edge-pixel accumulator with a synchronous clear that can
// preload the pixel arriving in the clearing cycle.
module edge_pixel_counter #(
   parameter int unsigned CNT_W = 20
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clear,
   input  logic             inc,
   output logic [CNT_W-1:0] count
);

   logic [CNT_W-1:0] count_q;
   logic [CNT_W-1:0] count_d;

   always_comb begin
      count_d = count_q;
      if (clear) begin
         count_d = CNT_W'(inc);
      end else if (inc && !(&count_q)) begin
         count_d = count_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count = count_q;

endmodule

// File: rtl/sobel_threshold_ctrl.sv
// Frame-synchronous threshold controller: counts edge pixels per frame and
// applies an auto-regulated or key-stepped threshold only between frames.
module sobel_threshold_ctrl
   import sobel_ctrl_pkg::*;
#(
   parameter int unsigned THR_INIT  = 250,
   parameter int unsigned THR_MIN   = 16,
   parameter int unsigned THR_MAX   = 1023,
   parameter int unsigned THR_STEP  = 8,
   parameter int unsigned TARGET_LO = 1000,
   parameter int unsigned TARGET_HI = 4000,
   parameter int unsigned CNT_W     = 20
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             post_frame_vsync,
   input  logic             post_frame_href,
   input  logic             post_frame_clken,
   input  logic             post_img_bit,
   input  logic             auto_en,
   input  logic             key_up,
   input  logic             key_down,
   output logic [THR_W-1:0] threshold,
   output logic [CNT_W-1:0] edge_count,
   output logic             frame_done
);

   localparam logic [THR_W-1:0] INIT_V = THR_W'(THR_INIT);
   localparam logic [THR_W-1:0] MIN_V  = THR_W'(THR_MIN);
   localparam logic [THR_W-1:0] MAX_V  = THR_W'(THR_MAX);
   localparam logic [THR_W-1:0] STEP_V = THR_W'(THR_STEP);

   state_e           state_q, state_d;
   logic             vsync_d;
   logic             vsync_rise;
   logic             qual_pixel;
   logic             active;
   logic             acc_clear;
   logic             acc_inc;
   logic [CNT_W-1:0] acc_count;

   logic [CNT_W-1:0] edge_count_q;
   logic [THR_W-1:0] thr_q;
   logic [THR_W-1:0] thr_next_q;
   logic [THR_W-1:0] thr_calc;
   logic [THR_W-1:0] pend_q, pend_d;
   logic             upd_up_q, upd_down_q;
   logic             frame_done_q;
   logic             cnt_above, cnt_below;

   assign vsync_rise = post_frame_vsync & ~vsync_d;
   assign qual_pixel = post_frame_clken & post_frame_href & post_img_bit;
   assign active     = (state_q != IDLE);

   // Rises during UPDATE/APPLY are degenerate frames and must not clear.
   assign acc_clear = vsync_rise & ((state_q == IDLE) | (state_q == ACCUM));
   assign acc_inc   = qual_pixel & active;

   edge_pixel_counter #(
      .CNT_W (CNT_W)
   ) u_counter (
      .clk   (clk),
      .rst_n (rst_n),
      .clear (acc_clear),
      .inc   (acc_inc),
      .count (acc_count)
   );

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (vsync_rise) state_d = ACCUM;
         ACCUM:   if (vsync_rise) state_d = UPDATE;
         UPDATE:  state_d = APPLY;
         APPLY:   state_d = ACCUM;
         default: state_d = IDLE;
      endcase
   end

   assign cnt_above = 32'(edge_count_q) > TARGET_HI;
   assign cnt_below = 32'(edge_count_q) < TARGET_LO;

   always_comb begin
      thr_calc = pend_q;
      if (auto_en) begin
         thr_calc = sat_step(thr_q, cnt_above, cnt_below, STEP_V, MIN_V, MAX_V);
      end
   end

   // Keys seen in UPDATE are held in upd_*_q and replayed on top of the new
   // threshold in APPLY, so they carry into the next frame's pending value.
   always_comb begin
      pend_d = pend_q;
      unique case (state_q)
         ACCUM:   pend_d = sat_step(pend_q, key_up, key_down, STEP_V, MIN_V, MAX_V);
         APPLY:   pend_d = sat_step(sat_step(thr_next_q, upd_up_q, upd_down_q,
                                             STEP_V, MIN_V, MAX_V),
                                    key_up, key_down, STEP_V, MIN_V, MAX_V);
         default: pend_d = pend_q;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         vsync_d      <= 1'b0;
         edge_count_q <= '0;
         thr_q        <= INIT_V;
         thr_next_q   <= INIT_V;
         pend_q       <= INIT_V;
         upd_up_q     <= 1'b0;
         upd_down_q   <= 1'b0;
         frame_done_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         vsync_d      <= post_frame_vsync;
         pend_q       <= pend_d;
         frame_done_q <= (state_q == APPLY);
         if (state_q == ACCUM && vsync_rise) begin
            edge_count_q <= acc_count;
         end
         if (state_q == UPDATE) begin
            thr_next_q <= thr_calc;
            upd_up_q   <= key_up;
            upd_down_q <= key_down;
         end
         if (state_q == APPLY) begin
            thr_q <= thr_next_q;
         end
      end
   end

   assign threshold  = thr_q;
   assign edge_count = edge_count_q;
   assign frame_done = frame_done_q;

endmodule

// File: doc/sobel_threshold_ctrl.md
# sobel_threshold_ctrl

Frame-synchronous threshold controller for the Sobel edge detector in the image-processing chain. Counts edge pixels on the detector's binary output each frame and, at every frame boundary, applies a new threshold (auto-regulated toward a target edge density, or manually stepped by key pulses). The threshold changes only between frames, so every frame is binarised with one constant value.

## Interface
- THR_INIT, 250: threshold after reset.
- THR_MIN, 16: lower saturation bound.
- THR_MAX, 1023: upper saturation bound (≤ 2047).
- THR_STEP, 8: increment/decrement per adjustment.
- TARGET_LO, 1000: auto mode; fewer edge pixels than this lowers the threshold.
- TARGET_HI, 4000: auto mode; more edge pixels than this raises the threshold.
- CNT_W, 20: edge counter width.

Ports:
- clk  in  1  pixel clock; single clock domain.
- rst_n  in  1  reset, asynchronous, active-low.
- post_frame_vsync  in  1  detector output vsync, active-high frame pulse.
- post_frame_href  in  1  detector output line valid.
- post_frame_clken  in  1  detector output pixel strobe.
- post_img_bit  in  1  detector edge bit.
- auto_en  in  1  1 = auto regulation, 0 = manual.
- key_up  in  1  single-cycle pulse, pre-debounced; manual +THR_STEP.
- key_down  in  1  single-cycle pulse, pre-debounced; manual −THR_STEP.
- threshold  out  11  active threshold driven to the detector.
- edge_count  out  CNT_W  edge pixel total of the last completed frame.
- frame_done  out  1  one-cycle pulse when threshold/edge_count update.

## Operation
- Qualified pixel = post_frame_clken & post_frame_href & post_img_bit.
- Frame boundary = vsync rise: post_frame_vsync high while the registered copy vsync_d is low.
- Accumulator counts qualified pixels; it saturates at all-ones and does not wrap.
- FSM:
  - IDLE: reset state; no counting. On vsync rise: clear accumulator, go to ACCUM. The first partial frame after reset is discarded.
  - ACCUM: count. On vsync rise: edge_count <= accumulator; clear the accumulator, counting the current-cycle qualified pixel as 1; go to UPDATE.
  - UPDATE (1 cycle): compute thr_next from the latched edge_count. Counting continues.
  - APPLY (1 cycle): threshold <= thr_next; frame_done = 1; go to ACCUM.
- Auto (auto_en sampled in UPDATE):
  - edge_count > TARGET_HI → threshold + THR_STEP.
  - edge_count < TARGET_LO → threshold − THR_STEP.
  - Otherwise hold.
- Manual: a pending register starts each frame equal to threshold.
  - key_up adds THR_STEP; key_down subtracts THR_STEP; keys are accepted in any state except IDLE.
  - key_up and key_down in the same cycle → no change.
  - The pending value is applied only in APPLY. Pulses arriving in UPDATE or APPLY roll into the next frame's pending value.
- Saturation: all arithmetic is done in 12 bits and clamped to [THR_MIN, THR_MAX]. No wrap at either bound.
- Mode switch mid-frame takes effect at the next UPDATE. Manual pending is re-seeded from threshold in APPLY.
- A vsync rise during UPDATE or APPLY (degenerate frame) is ignored.

## Timing
- Reset values: threshold = THR_INIT, edge_count = 0, frame_done = 0, state IDLE, accumulator 0, pending = THR_INIT.
- Async reset mid-frame returns to IDLE immediately. The next full frame is counted only after the following vsync rise.
- Vsync rise sampled at edge E0:
  - edge_count valid after E0.
  - UPDATE in cycle E0–E1.
  - threshold and frame_done change at E2.
  - frame_done low again at E3.
- Latency vsync rise → new threshold: 2 clocks. This lies within vertical blanking (href low), so no pixel sees a mixed threshold.
- Throughput: one qualified pixel per clock.

## Structure
- Package sobel_ctrl_pkg holds:
  - State enum {IDLE, ACCUM, UPDATE, APPLY}.
  - THR_W = 11.
  - Function sat_step(value, up, down, step, min, max) returning the clamped threshold.
- Sub-module edge_pixel_counter holds the saturating CNT_W counter, with sync clear-and-load (clear, inc → 0 or 1).
- Top level contains the FSM, vsync edge detect, manual pending register and threshold register.

## Test plan
- Reset, then two frames with 5000 edge pixels each, auto_en = 1 → first frame discarded; after the second vsync rise, edge_count = 5000 and threshold 250 → 258 two clocks later, with frame_done one cycle.
- Frames of 500 edge pixels, auto mode, run 40 frames → threshold steps 250, 242, … down to 16 and holds at 16; frames of 2000 pixels → threshold held.
- Manual mode: 3 key_up pulses plus 1 simultaneous up/down pair mid-frame → threshold stays 250 until the vsync rise, then becomes 274.
- Manual with threshold 1020: one key_up → 1023 (saturate); further key_up pulses → 1023.
- Accumulator saturation with CNT_W = 4: 20 edge pixels in a frame → edge_count = 15.
- Assert rst_n low mid-frame after 3000 pixels → threshold = 250, edge_count = 0 immediately; the next vsync rise counts nothing; the following one reports the correct full-frame count.
